// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared constants, checker states and bus decode for the CPU bus responder
package cpu_bus_pkg;

    localparam logic [3:0] CTRL_LOAD  = 4'b0111;
    localparam logic [3:0] CTRL_STORE = 4'b0011;

    localparam logic [1:0] PH_N0 = 2'b00;
    localparam logic [1:0] PH_N1 = 2'b01;
    localparam logic [1:0] PH_N2 = 2'b10;

    localparam logic [7:0] IO_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        S_N0,
        S_N1,
        S_N2,
        S_X,
        S_D
    } chk_state_t;

    typedef enum logic [2:0] {
        REQ_F0,
        REQ_F1,
        REQ_F2,
        REQ_LOAD,
        REQ_STORE,
        REQ_BAD
    } req_t;

    // ctrl[1:0] != 11 is always a fetch; the 11 codes are split by ctrl[3:2].
    function automatic req_t bus_decode(input logic [3:0] ctrl);
        req_t r;
        case (ctrl[1:0])
            PH_N0:   r = REQ_F0;
            PH_N1:   r = REQ_F1;
            PH_N2:   r = REQ_F2;
            default: begin
                if (ctrl == CTRL_LOAD)       r = REQ_LOAD;
                else if (ctrl == CTRL_STORE) r = REQ_STORE;
                else                         r = REQ_BAD;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - nibble-serial CPU bus signals with CPU and memory-side views
interface cpu_bus_responder_if;

    logic [7:0] bus_addr;
    logic [3:0] bus_ctrl;
    logic [3:0] bus_wdata;
    logic [3:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_ctrl,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_ctrl,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/cpu_bus_checker.sv
// rtl/cpu_bus_checker.sv - bus protocol FSM with sticky error flag and completed-fetch counter
module cpu_bus_checker
    import cpu_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  req_t        req_i,
    input  logic [9:0]  pc_i,
    output logic        proto_err_o,
    output logic [15:0] fetch_count_o
);

    chk_state_t  state_q;
    logic [9:0]  pc_q;
    logic        proto_err_q;
    logic [15:0] fetch_count_q;

    logic is_f0;
    logic same_pc;

    assign is_f0   = (req_i == REQ_F0);
    assign same_pc = (pc_i == pc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_N0;
            pc_q          <= '0;
            proto_err_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            if (is_f0) begin
                pc_q <= pc_i;
            end
            // Every state accepts nibble 0 as a (re)start; anything unexpected resyncs.
            case (state_q)
                S_N1: begin
                    if (is_f0) begin
                        state_q <= S_N1;
                    end else if (req_i == REQ_F1 && same_pc) begin
                        state_q <= S_N2;
                    end else begin
                        proto_err_q <= 1'b1;
                        state_q     <= S_N0;
                    end
                end
                S_N2: begin
                    if (req_i == REQ_F2 && same_pc) begin
                        state_q       <= S_X;
                        fetch_count_q <= fetch_count_q + 16'd1;
                    end else begin
                        proto_err_q <= 1'b1;
                        state_q     <= is_f0 ? S_N1 : S_N0;
                    end
                end
                S_X: begin
                    if (req_i == REQ_LOAD || req_i == REQ_STORE) begin
                        state_q <= S_D;
                    end else if (is_f0) begin
                        state_q <= S_N1;
                    end else begin
                        proto_err_q <= 1'b1;
                        state_q     <= S_N0;
                    end
                end
                default: begin
                    // S_N0 and S_D only accept a fresh nibble 0
                    if (is_f0) begin
                        state_q <= S_N1;
                    end else begin
                        proto_err_q <= 1'b1;
                        state_q     <= S_N0;
                    end
                end
            endcase
        end
    end

    assign proto_err_o   = proto_err_q;
    assign fetch_count_o = fetch_count_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - memory-side responder: program/data storage, I/O port, loader
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int PROG_AW = 6,
    parameter int DATA_AW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_bus_responder_if.slave  bus,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [11:0]         load_data,
    output logic                load_ready,
    output logic [3:0]          out_port,
    input  logic [3:0]          in_port,
    output logic                proto_err,
    output logic [15:0]         fetch_count
);

    localparam int          PROG_DEPTH = 1 << PROG_AW;
    localparam int          DATA_DEPTH = 1 << DATA_AW;
    localparam int          PTR_W      = PROG_AW + 1;
    localparam logic [8:0]  RAM_LIMIT  = 9'(DATA_DEPTH);

    logic [11:0] prog_mem [PROG_DEPTH];
    logic [3:0]  data_ram [DATA_DEPTH];

    logic [PTR_W-1:0] ptr_q;
    logic [3:0]       out_port_q;

    req_t               req;
    logic [9:0]         pc;
    logic [PROG_AW-1:0] word_idx;
    logic [11:0]        word;
    logic [DATA_AW-1:0] daddr;
    logic               in_ram;
    logic               is_io;
    logic               load_fire;
    logic [3:0]         rdata;

    assign req      = bus_decode(bus.bus_ctrl);
    assign pc       = {bus.bus_addr, bus.bus_ctrl[3:2]};
    assign word_idx = pc[PROG_AW-1:0];
    assign word     = prog_mem[word_idx];
    assign daddr    = bus.bus_addr[DATA_AW-1:0];
    assign in_ram   = ({1'b0, bus.bus_addr} < RAM_LIMIT);
    assign is_io    = (bus.bus_addr == IO_ADDR);

    always_comb begin
        rdata = 4'h0;
        case (req)
            REQ_F0:   rdata = word[3:0];
            REQ_F1:   rdata = word[7:4];
            REQ_F2:   rdata = word[11:8];
            REQ_LOAD: begin
                if (in_ram)     rdata = data_ram[daddr];
                else if (is_io) rdata = in_port;
            end
            default:  rdata = 4'h0;
        endcase
    end

    assign bus.bus_rdata = rdata;

    // Writes land on the closing edge, so a same-cycle fetch sees the old word
    // and the next cycle's LOAD sees the stored nibble.
    always_ff @(posedge clk) begin
        if (req == REQ_STORE && in_ram) begin
            data_ram[daddr] <= bus.bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            prog_mem[ptr_q[PROG_AW-1:0]] <= load_data;
        end
    end

    assign load_ready = ~ptr_q[PROG_AW];
    assign load_fire  = load_valid & load_ready & ~load_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            out_port_q <= 4'h0;
        end else begin
            if (load_start) begin
                ptr_q <= '0;
            end else if (load_fire) begin
                ptr_q <= ptr_q + PTR_W'(1);
            end
            if (req == REQ_STORE && is_io) begin
                out_port_q <= bus.bus_wdata;
            end
        end
    end

    assign out_port = out_port_q;

    cpu_bus_checker u_checker (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .pc_i          (pc),
        .proto_err_o   (proto_err),
        .fetch_count_o (fetch_count)
    );

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - self-checking bench for cpu_bus_responder
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [11:0] load_data = 12'h0;
    logic        load_ready;
    logic [3:0]  out_port;
    logic [3:0]  in_port = 4'h0;
    logic        proto_err;
    logic [15:0] fetch_count;

    always #5 clk = ~clk;

    cpu_bus_responder_if bus ();

    cpu_bus_responder #(.PROG_AW(6), .DATA_AW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .out_port    (out_port),
        .in_port     (in_port),
        .proto_err   (proto_err),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic [7:0] addr;
        logic [3:0] ctrl;
        logic [3:0] wdata;
        logic [3:0] inp;
        logic [3:0] exp;
    } vec_t;

    vec_t        tbl [18];
    logic [3:0]  exp_q [$];
    logic [11:0] prog_model [64];
    int          tb_ptr = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [11:0] w, input int k);
        logic [11:0] s;
        s = w >> (4 * k);
        return s[3:0];
    endfunction

    task automatic bus_cycle(input logic [7:0] addr, input logic [3:0] ctrl, input logic [3:0] wdata,
                             input logic [3:0] inp, input bit chk, input logic [3:0] exp);
        logic [3:0] e;
        bus.bus_addr  = addr;
        bus.bus_ctrl  = ctrl;
        bus.bus_wdata = wdata;
        in_port       = inp;
        if (chk) exp_q.push_back(exp);
        @(negedge clk);
        if (chk) begin
            e = exp_q.pop_front();
            check("rdata", {12'h0, bus.bus_rdata}, {12'h0, e});
        end
        @(posedge clk);
        #1;
    endtask

    // One loader cycle with the bus idling on nibble 0 of word 0.
    task automatic load_tick(input bit start, input bit valid, input logic [11:0] data, input bit chk);
        load_start = start;
        load_valid = valid;
        load_data  = data;
        if (chk) check("load_ready", {15'h0, load_ready}, {15'h0, (tb_ptr < 64)});
        bus_cycle(8'h00, 4'h0, 4'h0, 4'h0, chk, nib(prog_model[0], 0));
        if (start) begin
            tb_ptr = 0;
        end else if (valid && tb_ptr < 64) begin
            prog_model[tb_ptr] = data;
            tb_ptr++;
        end
        load_start = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("err_async_clear", {15'h0, proto_err}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tb_ptr = 0;
    endtask

    task automatic fetch_word(input logic [7:0] addr, input logic [1:0] sub);
        logic [11:0] w;
        logic [9:0]  pc;
        pc = {addr, sub};
        w  = prog_model[pc[5:0]];
        bus_cycle(addr, {sub, 2'b00}, 4'h0, 4'h0, 1'b1, nib(w, 0));
        bus_cycle(addr, {sub, 2'b01}, 4'h0, 4'h0, 1'b1, nib(w, 1));
        bus_cycle(addr, {sub, 2'b10}, 4'h0, 4'h0, 1'b1, nib(w, 2));
    endtask

    initial begin
        bus.bus_addr  = 8'h00;
        bus.bus_ctrl  = 4'h0;
        bus.bus_wdata = 4'h0;
        for (int i = 0; i < 64; i++) prog_model[i] = 12'h000;

        tbl[0]  = '{8'h00, 4'h4, 4'h0, 4'h0, 4'h2};
        tbl[1]  = '{8'h00, 4'h5, 4'h0, 4'h0, 4'h1};
        tbl[2]  = '{8'h00, 4'h6, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{8'h07, 4'h3, 4'h9, 4'h0, 4'h0};
        tbl[4]  = '{8'h07, 4'h7, 4'h0, 4'h0, 4'h9};
        tbl[5]  = '{8'h40, 4'h7, 4'h0, 4'h0, 4'h0};
        tbl[6]  = '{8'hFF, 4'h3, 4'hC, 4'h0, 4'h0};
        tbl[7]  = '{8'hFF, 4'h7, 4'h0, 4'h3, 4'h3};
        tbl[8]  = '{8'h1F, 4'h3, 4'h6, 4'h3, 4'h0};
        tbl[9]  = '{8'h1F, 4'h7, 4'h0, 4'h3, 4'h6};
        tbl[10] = '{8'h20, 4'h3, 4'h7, 4'h3, 4'h0};
        tbl[11] = '{8'h20, 4'h7, 4'h0, 4'h3, 4'h0};
        tbl[12] = '{8'h00, 4'h0, 4'h0, 4'h3, 4'h3};
        tbl[13] = '{8'h00, 4'h1, 4'h0, 4'h0, 4'hA};
        tbl[14] = '{8'h00, 4'h2, 4'h0, 4'h0, 4'h5};
        tbl[15] = '{8'h00, 4'h8, 4'h0, 4'h0, 4'hF};
        tbl[16] = '{8'h00, 4'h9, 4'h0, 4'h0, 4'hF};
        tbl[17] = '{8'h00, 4'hA, 4'h0, 4'h0, 4'hF};

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_port", {12'h0, out_port}, 16'h0);
        check("rst_proto_err", {15'h0, proto_err}, 16'h0);
        check("rst_fetch_count", fetch_count, 16'h0);
        check("rst_load_ready", {15'h0, load_ready}, 16'h1);

        load_tick(1'b0, 1'b1, 12'h5A3, 1'b0);
        load_tick(1'b0, 1'b1, 12'h012, 1'b0);
        load_tick(1'b0, 1'b1, 12'hFFF, 1'b0);

        for (int i = 0; i < 18; i++) begin
            bus_cycle(tbl[i].addr, tbl[i].ctrl, tbl[i].wdata, tbl[i].inp, 1'b1, tbl[i].exp);
            if (i == 2) begin
                check("first_fetch_count", fetch_count, 16'h1);
                check("first_proto_err", {15'h0, proto_err}, 16'h0);
            end
            if (i == 6) check("out_port_store", {12'h0, out_port}, 16'hC);
        end
        check("table_fetch_count", fetch_count, 16'h3);
        check("table_proto_err", {15'h0, proto_err}, 16'h1);

        do_reset();
        check("rst2_fetch_count", fetch_count, 16'h0);
        check("rst2_out_port", {12'h0, out_port}, 16'h0);
        check("rst2_load_ready", {15'h0, load_ready}, 16'h1);

        // Fill all 64 words; first tick overwrites word 0 while it is being fetched.
        for (int i = 0; i < 64; i++) load_tick(1'b0, 1'b1, 12'(i * 37 + 1), 1'b1);
        check("full_load_ready", {15'h0, load_ready}, 16'h0);
        load_tick(1'b0, 1'b1, 12'hEEE, 1'b1);
        load_tick(1'b1, 1'b1, 12'hABC, 1'b1);
        check("restart_load_ready", {15'h0, load_ready}, 16'h1);
        fetch_word(8'h00, 2'b00);
        fetch_word(8'h0F, 2'b11);
        bus_cycle(8'h10, 4'h0, 4'h0, 4'h0, 1'b1, nib(prog_model[0], 0));
        check("fill_proto_err", {15'h0, proto_err}, 16'h0);
        check("fill_fetch_count", fetch_count, 16'h2);

        bus_cycle(8'h01, 4'h0, 4'h0, 4'h0, 1'b1, nib(prog_model[4], 0));
        bus_cycle(8'h01, 4'h5, 4'h0, 4'h0, 1'b1, nib(prog_model[5], 1));
        check("idx_mismatch_err", {15'h0, proto_err}, 16'h1);
        fetch_word(8'h01, 2'b00);
        check("err_sticky", {15'h0, proto_err}, 16'h1);
        do_reset();
        check("err_after_reset", {15'h0, proto_err}, 16'h0);

        fetch_word(8'h00, 2'b00);
        bus_cycle(8'h07, 4'hF, 4'h5, 4'h0, 1'b1, 4'h0);
        check("invalid_err", {15'h0, proto_err}, 16'h1);
        bus_cycle(8'h07, 4'h7, 4'h0, 4'h0, 1'b1, 4'h9);
        do_reset();

        bus_cycle(8'h00, 4'h0, 4'h0, 4'h0, 1'b1, nib(prog_model[0], 0));
        fetch_word(8'h00, 2'b01);
        check("jump_proto_err", {15'h0, proto_err}, 16'h0);
        check("jump_fetch_count", fetch_count, 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
